// File: rtl/lc3_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : lc3_mem_responder
// Purpose : LC-3 MAR/MDR memory-port responder. Serves a word-addressed,
//           mirrored RAM plus the device page (KBSR/KBDR/DSR/DDR/MCR) and
//           answers each held request with a one-cycle ready pulse after a
//           programmable number of wait states.
// Rev     : 1.0  initial release
// ============================================================================
module lc3_mem_responder #(
  parameter int ADDR_BITS   = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        rdy,
  output logic [15:0] rdata,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        dd_valid,
  output logic [7:0]  dd_data,
  input  logic        dd_ready,
  output logic        kb_int,
  output logic        halt
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, COOL} state_t;

  localparam int RAM_WORDS = 1 << ADDR_BITS;

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic        we_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;

  logic [15:0] mem [0:RAM_WORDS-1];

  logic        kbsr_rdy, kbsr_ie, dsr_rdy, mcr_run;
  logic [7:0]  kbdr;

  // Transaction decode, all from the latched request
  logic        commit, wr, rd, is_dev;
  logic        a_kbsr, a_kbdr, a_dsr, a_ddr, a_mcr;
  logic        kbdr_rd, hs;
  logic [15:0] rd_val;
  logic [ADDR_BITS-1:0] ram_idx;

  assign commit  = (state == RESP);
  assign wr      = commit & we_q;
  assign rd      = commit & ~we_q;
  assign is_dev  = (addr_q[15:9] == 7'h7F);
  assign a_kbsr  = (addr_q == 16'hFE00);
  assign a_kbdr  = (addr_q == 16'hFE02);
  assign a_dsr   = (addr_q == 16'hFE04);
  assign a_ddr   = (addr_q == 16'hFE06);
  assign a_mcr   = (addr_q == 16'hFFFE);
  assign ram_idx = addr_q[ADDR_BITS-1:0];
  assign kbdr_rd = rd & a_kbdr;
  assign hs      = dd_valid & dd_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; COOL gives a held req one dead cycle before re-acceptance
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req) state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (cnt == 4'd1) state_next = RESP;
      RESP: state_next = COOL;
      COOL: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the request on acceptance and run the wait-state counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
    end else if (state == IDLE && req) begin
      cnt     <= 4'(WAIT_CYCLES);
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  // RAM write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr && !is_dev) mem[ram_idx] <= wdata_q;
  end

  // Read multiplexer across RAM and device registers
  always_comb begin
    rd_val = 16'h0000;
    if (!is_dev) begin
      rd_val = mem[ram_idx];
    end else begin
      case (addr_q)
        16'hFE00: rd_val = {kbsr_rdy, kbsr_ie, 14'h0000};
        16'hFE02: rd_val = {8'h00, kbdr};
        16'hFE04: rd_val = {dsr_rdy, 15'h0000};
        16'hFE06: rd_val = {8'h00, dd_data};
        16'hFFFE: rd_val = {mcr_run, 15'h0000};
        default:  rd_val = 16'h0000;
      endcase
    end
  end

  // Ready pulse and read data register, both launched at the RESP edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy   <= 1'b0;
      rdata <= 16'h0000;
    end else begin
      rdy <= commit;
      if (rd) rdata <= rd_val;
    end
  end

  // Keyboard registers; a new character wins over a same-edge KBDR read clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kbsr_rdy <= 1'b0;
      kbsr_ie  <= 1'b0;
      kbdr     <= 8'h00;
    end else begin
      if (kb_valid && (!kbsr_rdy || kbdr_rd)) begin
        kbdr     <= kb_data;
        kbsr_rdy <= 1'b1;
      end else if (kbdr_rd) begin
        kbsr_rdy <= 1'b0;
      end
      if (wr && a_kbsr) kbsr_ie <= wdata_q[14];
    end
  end

  // Display registers; a handshake completing on the same edge frees DDR for the write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dsr_rdy  <= 1'b1;
      dd_valid <= 1'b0;
      dd_data  <= 8'h00;
    end else if (wr && a_ddr && (dsr_rdy || hs)) begin
      dd_data  <= wdata_q[7:0];
      dd_valid <= 1'b1;
      dsr_rdy  <= 1'b0;
    end else if (hs) begin
      dd_valid <= 1'b0;
      dsr_rdy  <= 1'b1;
    end
  end

  // Machine control register and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcr_run <= 1'b1;
      kb_int  <= 1'b0;
      halt    <= 1'b0;
    end else begin
      if (wr && a_mcr) mcr_run <= wdata_q[15];
      kb_int <= kbsr_rdy & kbsr_ie;
      halt   <= ~mcr_run;
    end
  end

endmodule
`default_nettype wire
